// File: rtl/dmem_pkg.sv
// Shared constants and state encoding for the data-memory controller.
package dmem_pkg;

  localparam int unsigned RAM_BYTES_DEF = 8192;
  localparam int unsigned IDX_W_DEF     = $clog2(RAM_BYTES_DEF) - 2;
  localparam int unsigned LANES         = 4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/dmem_array.sv
// Byte-lane-masked single-port synchronous RAM with registered read and one preloaded word.
// Read data updates only on an enabled access, so it holds while the response is stalled.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned WORDS     = RAM_BYTES_DEF / 4,
  parameter int unsigned IDX_W     = IDX_W_DEF,
  parameter int unsigned INIT_IDX  = 0,
  parameter logic [31:0] INIT_DATA = 32'h0
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic [LANES-1:0] we_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  // Power-up contents; a reset never touches the array.
  logic [31:0] mem_q [WORDS] = '{INIT_IDX: INIT_DATA, default: '0};
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int i = 0; i < LANES; i++) begin
        if (we_i[i]) begin
          mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Valid/ready data-memory controller: one access per cycle, response registered at the accepting edge.
// A stalled response blocks new requests; consuming it and accepting a new one share a cycle.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned RAM_BYTES = RAM_BYTES_DEF,
  parameter logic [31:0] INIT_ADDR = 32'h0000_1000,
  parameter logic [31:0] INIT_DATA = 32'h1234_5678
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW       = $clog2(RAM_BYTES);
  localparam int unsigned IDX_W    = AW - 2;
  localparam int unsigned WORDS    = RAM_BYTES / 4;
  localparam int unsigned INIT_IDX = int'(INIT_ADDR[AW-1:2]);

  state_e              state_q, state_d;
  logic                err_q, err_d;
  logic                load_q, load_d;
  logic                accept;
  logic                oob;
  logic [LANES-1:0]    arr_we;
  logic [31:0]         arr_rdata;
  logic                unused_addr_lsbs;

  assign unused_addr_lsbs = ^req_addr[1:0];

  assign rsp_valid = (state_q == ST_FULL);
  assign req_ready = !rst && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;
  assign oob       = |req_addr[31:AW];
  assign arr_we    = (req_we && !oob) ? req_wmask : '0;

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    load_d  = load_q;
    if (accept) begin
      err_d  = oob;
      load_d = !req_we;
    end
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (rsp_ready && !accept) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      load_q  <= load_d;
    end
  end

  // Out-of-range accesses never reach the array, so they cannot alias onto a real word.
  dmem_array #(
    .WORDS     (WORDS),
    .IDX_W     (IDX_W),
    .INIT_IDX  (INIT_IDX),
    .INIT_DATA (INIT_DATA)
  ) u_array (
    .clk_i   (clk),
    .en_i    (accept && !oob),
    .we_i    (arr_we),
    .idx_i   (req_addr[AW-1:2]),
    .wdata_i (req_wdata),
    .rdata_o (arr_rdata)
  );

  assign rsp_rdata = (rsp_valid && load_q && !err_q) ? arr_rdata : 32'h0;
  assign rsp_err   = rsp_valid && err_q;

endmodule
